// File: rtl/sys_o_pkg.sv
// Shared types and default sizing for the sys_out write-side sequencer.
package sys_o_pkg;

  localparam int DEF_FEATURE_BITS = 4;
  localparam int DEF_P            = 4;
  localparam int DEF_GAMMA        = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_AG = 3'd2,
    NEXT    = 3'd3,
    FIN     = 3'd4
  } sched_state_t;

  typedef logic [2*DEF_FEATURE_BITS-1:0] dpr_addr_t;

endpackage

// File: rtl/sys_o_sched.sv
// Launches ag_o_ex once per output row block, offsets its addresses by a
// per-block base, and shares the DPR port with a host readout (AG first).
module sys_o_sched
  import sys_o_pkg::*;
#(
  parameter int FEATURE_BITS = DEF_FEATURE_BITS,
  parameter int P            = DEF_P,
  parameter int GAMMA        = DEF_GAMMA,
  parameter int BLK_STRIDE   = P
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      ag_start,
  input  logic                      ag_done,
  input  logic                      ag_valid,
  input  logic [2*FEATURE_BITS-1:0] ag_address,
  input  logic                      rd_req,
  input  logic [2*FEATURE_BITS-1:0] rd_addr,
  output logic                      rd_gnt,
  output logic                      dpr_we,
  output logic [2*FEATURE_BITS-1:0] dpr_addr,
  output logic [2*FEATURE_BITS-1:0] blk_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = 2 * FEATURE_BITS;
  localparam logic [AW-1:0] LAST_BLK = AW'(GAMMA - 1);
  localparam logic [AW-1:0] STRIDE   = AW'(BLK_STRIDE);

  sched_state_t  state;
  logic [AW-1:0] base;
  logic [AW-1:0] phys;

  // Address wraps modulo 2^AW by construction of the adder width.
  assign phys   = base + ag_address;
  assign rd_gnt = !ag_valid && rd_req;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      base     <= '0;
      blk_idx  <= '0;
      ag_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ag_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LAUNCH;
            blk_idx  <= '0;
            base     <= '0;
            ag_start <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LAUNCH: state <= WAIT_AG;
        WAIT_AG: begin
          if (ag_done) begin
            if (blk_idx == LAST_BLK) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          blk_idx  <= blk_idx + 1'b1;
          base     <= base + STRIDE;
          state    <= LAUNCH;
          ag_start <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // With no request the address register keeps its last value.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      dpr_we   <= 1'b0;
      dpr_addr <= '0;
    end else begin
      dpr_we <= ag_valid;
      if (ag_valid) begin
        dpr_addr <= phys;
      end else if (rd_req) begin
        dpr_addr <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_sys_o_sched.sv
// Directed + randomized bench for sys_o_sched with a block-level address model.
module tb_sys_o_sched;
  import sys_o_pkg::*;

  localparam int G      = 3;
  localparam int STRIDE = 4;

  logic      sys_clk;
  logic      reset_n;
  logic      start, ag_done, ag_valid, rd_req;
  dpr_addr_t ag_address, rd_addr;
  logic      ag_start, rd_gnt, dpr_we, busy, done;
  dpr_addr_t dpr_addr, blk_idx;

  logic       w_start, w_ag_done, w_ag_valid, w_rd_req;
  logic [3:0] w_ag_address, w_rd_addr;
  logic       w_ag_start, w_rd_gnt, w_dpr_we, w_busy, w_done;
  logic [3:0] w_dpr_addr, w_blk_idx;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference state: block currently being written and expected DPR registers.
  int        m_blk = 0;
  logic      m_we  = 1'b0;
  dpr_addr_t m_addr = '0;

  sys_o_sched #(.FEATURE_BITS(4), .P(4), .GAMMA(G), .BLK_STRIDE(STRIDE)) u_dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .ag_start(ag_start),
    .ag_done(ag_done), .ag_valid(ag_valid), .ag_address(ag_address),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .dpr_we(dpr_we),
    .dpr_addr(dpr_addr), .blk_idx(blk_idx), .busy(busy), .done(done)
  );

  sys_o_sched #(.FEATURE_BITS(2), .P(4), .GAMMA(2), .BLK_STRIDE(12)) u_wrap (
    .sys_clk(sys_clk), .reset_n(reset_n), .start(w_start), .ag_start(w_ag_start),
    .ag_done(w_ag_done), .ag_valid(w_ag_valid), .ag_address(w_ag_address),
    .rd_req(w_rd_req), .rd_addr(w_rd_addr), .rd_gnt(w_rd_gnt), .dpr_we(w_dpr_we),
    .dpr_addr(w_dpr_addr), .blk_idx(w_blk_idx), .busy(w_busy), .done(w_done)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One cycle of stimulus: check the combinational grant, then the registered port.
  task automatic apply(input logic v, input dpr_addr_t a, input logic dn,
                       input logic rq, input dpr_addr_t ra, input logic st);
    ag_valid = v; ag_address = a; ag_done = dn; rd_req = rq; rd_addr = ra; start = st;
    #1;
    chk("rd_gnt", 32'(rd_gnt), 32'(!v && rq));
    if (v) begin
      m_we   = 1'b1;
      m_addr = 8'((m_blk * STRIDE + int'(a)) % 256);
    end else begin
      m_we = 1'b0;
      if (rq) m_addr = ra;
    end
    tick();
    chk("dpr_we", 32'(dpr_we), 32'(m_we));
    chk("dpr_addr", 32'(dpr_addr), 32'(m_addr));
    ag_valid = 1'b0; ag_done = 1'b0; rd_req = 1'b0; start = 1'b0;
  endtask

  task automatic run(input bit contention, input bit randomized);
    int nb;
    logic v;
    apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("busy_run", 32'(busy), 32'd1);
    for (int b = 0; b < G; b++) begin
      chk("ag_start_hi", 32'(ag_start), 32'd1);
      chk("blk_idx", 32'(blk_idx), 32'(b));
      m_blk = b;
      nb = randomized ? int'($urandom_range(1, 6)) : 4;
      for (int i = 0; i < nb; i++) begin
        if (contention && b == 0) begin
          apply(1'b1, 8'(i), 1'b0, 1'b1, 8'h20, 1'b0);
        end else if (randomized) begin
          v = ($urandom_range(0, 3) != 0);
          apply(v, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'(i == 1));
        end else begin
          apply(1'b1, 8'(i), 1'b0, 1'b0, '0, 1'b0);
        end
        chk("ag_start_lo", 32'(ag_start), 32'd0);
        chk("done_lo", 32'(done), 32'd0);
      end
      // Final beat may coincide with ag_done and must still use this block's base.
      v = randomized ? ((b == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      apply(v, 8'($urandom_range(0, 15)), 1'b1, 1'b0, '0, 1'b0);
      if (b == G - 1) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_fin", 32'(busy), 32'd1);
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("done_end", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        tick();
        chk("fin_start_dropped", 32'(busy), 32'd0);
        chk("fin_no_launch", 32'(ag_start), 32'd0);
      end else begin
        chk("next_no_start", 32'(ag_start), 32'd0);
        chk("next_no_done", 32'(done), 32'd0);
        if (contention && b == 0)
          apply(1'b0, '0, 1'b0, 1'b1, 8'h20, 1'b0);
        else
          apply(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 0; ag_done = 0; ag_valid = 0; rd_req = 0; ag_address = '0; rd_addr = '0;
    w_start = 0; w_ag_done = 0; w_ag_valid = 0; w_rd_req = 0; w_ag_address = '0; w_rd_addr = '0;
    #3;
    chk("rst_dpr_we", 32'(dpr_we), 32'd0);
    chk("rst_dpr_addr", 32'(dpr_addr), 32'd0);
    chk("rst_blk_idx", 32'(blk_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ag_start", 32'(ag_start), 32'd0);
    #9 reset_n = 1'b1;
    tick();

    // Read granted while idle; then ag_done while idle is ignored.
    apply(1'b0, '0, 1'b0, 1'b1, 8'h5A, 1'b0);
    apply(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_launch", 32'(ag_start), 32'd0);

    // Directed full run with read contention on block 0.
    run(1'b1, 1'b0);
    for (int r = 0; r < 6; r++) run(1'b0, 1'b1);

    // Wrap: second block base is 12 in a 4-bit address space.
    w_start = 1; tick(); w_start = 0;
    chk("w_launch", 32'(w_ag_start), 32'd1);
    tick();
    w_ag_done = 1; tick(); w_ag_done = 0;
    tick();
    chk("w_blk_idx", 32'(w_blk_idx), 32'd1);
    w_ag_valid = 1; w_ag_address = 4'd6; tick(); w_ag_valid = 0;
    chk("w_dpr_we", 32'(w_dpr_we), 32'd1);
    chk("w_dpr_addr", 32'(w_dpr_addr), 32'd2);
    w_ag_done = 1; tick(); w_ag_done = 0;
    chk("w_done", 32'(w_done), 32'd1);
    tick();

    // Mid-run reset during block 1.
    apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    m_blk = 0;
    for (int i = 0; i < 3; i++) apply(1'b1, 8'(i), 1'b0, 1'b0, '0, 1'b0);
    apply(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("mid_blk1", 32'(blk_idx), 32'd1);
    m_blk = 1;
    apply(1'b1, 8'd2, 1'b0, 1'b0, '0, 1'b0);
    ag_valid = 1'b1; ag_address = 8'd3;
    reset_n = 1'b0;
    #1;
    chk("mrst_dpr_we", 32'(dpr_we), 32'd0);
    chk("mrst_dpr_addr", 32'(dpr_addr), 32'd0);
    chk("mrst_blk_idx", 32'(blk_idx), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ag_start", 32'(ag_start), 32'd0);
    ag_valid = 1'b0;
    tick();
    chk("mrst_no_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    m_we = 1'b0; m_addr = '0; m_blk = 0;
    tick();
    run(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
